noise_gen_mc: RTL and testbench

Parametrised multi-channel noise source for the audio path; successor to the single 16-bit LFSR generator. Each channel runs its own 32-bit Galois LFSR and advances once per accepted sample strobe. Channel seeds are decorrelated. Modes: white, brown (leaky integrator) and silent. A per-block arithmetic attenuation is applied. Results are delivered with a valid/ready handshake toward the mixer/codec interface.

---
 rtl/noise_gen_pkg.sv | 27 ++
 rtl/noise_lfsr_ch.sv | 85 ++++++++
 rtl/noise_gen_mc.sv | 116 +++++++++++
 tb/tb_noise_gen_mc.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/noise_gen_pkg.sv
// Shared constants and helpers for the multi-channel noise generator.
package noise_gen_pkg;

    localparam logic [31:0] LFSR_MASK   = 32'h80200003;
    localparam logic [31:0] SEED_STRIDE = 32'h9E3779B9;

    localparam logic [1:0] MODE_WHITE  = 2'b00;
    localparam logic [1:0] MODE_BROWN  = 2'b01;
    localparam logic [1:0] MODE_SILENT = 2'b10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_STEP  = 2'd1;
    localparam logic [1:0] ST_SHAPE = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

    // Golden-ratio stride decorrelates channels; zero would freeze the LFSR.
    function automatic logic [31:0] seed_for_ch(input logic [31:0] base, input int unsigned ch);
        logic [31:0] v;
        v = base ^ (ch * SEED_STRIDE);
        return (v == 32'h0) ? 32'h00000001 : v;
    endfunction

endpackage

// File: rtl/noise_lfsr_ch.sv
// One noise channel: LFSR, brown integrator, attenuation and output register.
module noise_lfsr_ch
    import noise_gen_pkg::*;
#(
    parameter int          WIDTH        = 16,
    parameter int          LP_SHIFT     = 4,
    parameter logic [31:0] DEFAULT_SEED = 32'h0000ACE1,
    parameter int          CH           = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             seed_load,
    input  logic [31:0]      seed,
    input  logic             step_en,
    input  logic             shape_en,
    input  logic [1:0]       mode,
    input  logic [3:0]       amp_shift,
    output logic [WIDTH-1:0] sample_out
);

    localparam int          MAX_SHIFT  = WIDTH - 1;
    localparam logic [31:0] RESET_SEED = seed_for_ch(DEFAULT_SEED, CH);

    logic [31:0]             lfsr_q, lfsr_d;
    logic [WIDTH-1:0]        y_state_q, y_state_d;
    logic [WIDTH-1:0]        out_q, out_d;

    logic signed [WIDTH-1:0] x;
    logic signed [WIDTH:0]   diff;
    logic signed [WIDTH:0]   delta;
    logic signed [WIDTH:0]   brown_sum;
    logic signed [WIDTH-1:0] y_sel;
    logic [4:0]              amp_eff;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        lfsr_d    = lfsr_q;
        y_state_d = y_state_q;
        out_d     = out_q;

        x         = $signed(lfsr_q[31 -: WIDTH]);
        diff      = {x[WIDTH-1], x} - {y_state_q[WIDTH-1], y_state_q};
        delta     = diff >>> LP_SHIFT;
        brown_sum = {y_state_q[WIDTH-1], y_state_q} + delta;

        case (mode)
            MODE_WHITE: y_sel = x;
            MODE_BROWN: y_sel = brown_sum[WIDTH-1:0];
            default:    y_sel = '0;
        endcase

        amp_eff = ({1'b0, amp_shift} > 5'(MAX_SHIFT)) ? 5'(MAX_SHIFT) : {1'b0, amp_shift};

        if (seed_load) begin
            lfsr_d    = seed_for_ch(seed, CH);
            y_state_d = '0;
        end else begin
            if (step_en) begin
                lfsr_d = lfsr_step(lfsr_q);
            end
            if (shape_en) begin
                out_d = y_sel >>> amp_eff;
                if (mode == MODE_BROWN) begin
                    y_state_d = brown_sum[WIDTH-1:0];
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q    <= RESET_SEED;
            y_state_q <= '0;
            out_q     <= '0;
        end else begin
            lfsr_q    <= lfsr_d;
            y_state_q <= y_state_d;
            out_q     <= out_d;
        end
    end

    assign sample_out = out_q;

endmodule

// File: rtl/noise_gen_mc.sv
// Multi-channel noise source: sample FSM, valid/ready handshake and overrun tracking.
module noise_gen_mc
    import noise_gen_pkg::*;
#(
    parameter int          WIDTH        = 16,
    parameter int          NUM_CH       = 2,
    parameter int          LP_SHIFT     = 4,
    parameter logic [31:0] DEFAULT_SEED = 32'h0000ACE1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    sample_tick,
    input  logic [1:0]              mode,
    input  logic [3:0]              amp_shift,
    input  logic                    seed_load,
    input  logic [31:0]             seed,
    output logic [NUM_CH*WIDTH-1:0] noise_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun
);

    logic [1:0] state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic [3:0] amp_q, amp_d;
    logic       out_valid_q, out_valid_d;
    logic       overrun_q, overrun_d;
    logic       step_en;
    logic       shape_en;
    logic       tick;

    assign tick = enable && sample_tick;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        amp_d       = amp_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        step_en     = 1'b0;
        shape_en    = 1'b0;

        if (seed_load) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tick) state_d = ST_STEP;
                end
                ST_STEP: begin
                    step_en = 1'b1;
                    mode_d  = mode;
                    amp_d   = amp_shift;
                    state_d = ST_SHAPE;
                    if (tick) overrun_d = 1'b1;
                end
                ST_SHAPE: begin
                    shape_en    = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                    if (tick) overrun_d = 1'b1;
                end
                default: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = tick ? ST_STEP : ST_IDLE;
                    end else if (tick) begin
                        overrun_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_WHITE;
            amp_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            amp_q       <= amp_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        noise_lfsr_ch #(
            .WIDTH        (WIDTH),
            .LP_SHIFT     (LP_SHIFT),
            .DEFAULT_SEED (DEFAULT_SEED),
            .CH           (c)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .seed_load  (seed_load),
            .seed       (seed),
            .step_en    (step_en),
            .shape_en   (shape_en),
            .mode       (mode_q),
            .amp_shift  (amp_q),
            .sample_out (noise_out[c*WIDTH +: WIDTH])
        );
    end

    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_noise_gen_mc.sv
// Scoreboard bench for noise_gen_mc (WIDTH=16, NUM_CH=2) with hand-computed samples.
module tb_noise_gen_mc;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        sample_tick;
    logic [1:0]  mode;
    logic [3:0]  amp_shift;
    logic        seed_load;
    logic [31:0] seed;
    logic [31:0] noise_out;
    logic        out_valid;
    logic        out_ready;
    logic        overrun;

    typedef struct {
        logic [31:0] data;
        logic [31:0] mask;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;

    localparam logic [31:0] BOTH = 32'hFFFF_FFFF;
    localparam logic [31:0] CH0  = 32'h0000_FFFF;

    noise_gen_mc #(
        .WIDTH        (16),
        .NUM_CH       (2),
        .LP_SHIFT     (4),
        .DEFAULT_SEED (32'h0000ACE1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .sample_tick (sample_tick),
        .mode        (mode),
        .amp_shift   (amp_shift),
        .seed_load   (seed_load),
        .seed        (seed),
        .noise_out   (noise_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_sample(input logic [31:0] data, input logic [31:0] mask, input string name);
        exp_t e;
        e.data = data;
        e.mask = mask;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic pulse_seed(input logic [31:0] s);
        @(negedge clk);
        seed      = s;
        seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 8; i++) begin
            if (out_valid) break;
            @(negedge clk);
        end
        check({name, "_valid_seen"}, {31'b0, out_valid}, 32'd1);
    endtask

    task automatic run_sample(input string name);
        tick();
        wait_valid(name);
        @(negedge clk);
    endtask

    // Monitor: every rising out_valid is one delivered sample.
    initial begin : monitor
        exp_t e;
        logic last_valid;
        last_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                last_valid = 1'b0;
            end else begin
                if (out_valid && !last_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_sample", noise_out, 32'hxxxx_xxxx);
                    end else begin
                        e = exp_q.pop_front();
                        check(e.name, noise_out & e.mask, e.data & e.mask);
                    end
                end
                last_valid = out_valid;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        reset       = 1'b1;
        enable      = 1'b1;
        sample_tick = 1'b0;
        mode        = 2'b00;
        amp_shift   = 4'd0;
        seed_load   = 1'b0;
        seed        = 32'h0;
        out_ready   = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_noise_out", noise_out, 32'h0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_overrun", {31'b0, overrun}, 32'd0);
        reset = 1'b0;

        // White, full scale; ch0 LFSR 80205673, ch1 4F1BEAAC.
        expect_sample(32'h4F1B_8020, BOTH, "white_first");
        tick();
        check("lat_e0", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        check("lat_e1", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        check("lat_e2", {31'b0, out_valid}, 32'd1);
        @(negedge clk);
        check("ack_clears_valid", {31'b0, out_valid}, 32'd0);

        pulse_seed(32'h0000ACE1);
        amp_shift = 4'd1;
        expect_sample(32'h278D_C010, BOTH, "white_amp1");
        run_sample("white_amp1");

        pulse_seed(32'h0000ACE1);
        amp_shift = 4'd0;
        mode      = 2'b01;
        expect_sample(32'h04F1_F802, BOTH, "brown_first");
        run_sample("brown_first");

        // Overrun while the consumer stalls.
        pulse_seed(32'h0000ACE1);
        mode      = 2'b00;
        out_ready = 1'b0;
        expect_sample(32'h0000_8020, CH0, "stall_first");
        tick();
        wait_valid("stall_first");
        tick();
        check("overrun_set", {31'b0, overrun}, 32'd1);
        check("stall_hold_value", noise_out & CH0, 32'h0000_8020);
        check("stall_still_valid", {31'b0, out_valid}, 32'd1);
        expect_sample(32'h0000_C030, CH0, "after_drop_step2");
        @(negedge clk);
        out_ready   = 1'b1;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        wait_valid("after_drop_step2");
        @(negedge clk);
        check("overrun_sticky", {31'b0, overrun}, 32'd1);

        // seed_load with zero seed and a coincident tick.
        @(negedge clk);
        seed        = 32'h0;
        seed_load   = 1'b1;
        sample_tick = 1'b1;
        @(negedge clk);
        seed_load   = 1'b0;
        sample_tick = 1'b0;
        check("seed_clears_overrun", {31'b0, overrun}, 32'd0);
        repeat (3) @(negedge clk);
        check("coinc_tick_dropped", {31'b0, out_valid}, 32'd0);
        check("coinc_no_overrun", {31'b0, overrun}, 32'd0);
        expect_sample(32'hCF3B_8020, BOTH, "zero_seed");
        run_sample("zero_seed");

        // Silent for four ticks, then white gives the fifth step.
        pulse_seed(32'h0000ACE1);
        mode = 2'b10;
        for (int i = 0; i < 4; i++) begin
            expect_sample(32'h0, BOTH, "silent");
            run_sample("silent");
        end
        mode = 2'b00;
        expect_sample(32'h0000_D836, CH0, "white_step5");
        run_sample("white_step5");

        // Overrun during STEP, then reset during SHAPE.
        pulse_seed(32'h0000ACE1);
        tick();
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        check("overrun_in_step", {31'b0, overrun}, 32'd1);
        #1 reset = 1'b1;
        #1;
        check("async_rst_noise_out", noise_out, 32'h0);
        check("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("async_rst_overrun", {31'b0, overrun}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        expect_sample(32'h4F1B_8020, BOTH, "post_reset_first");
        run_sample("post_reset_first");

        // In-flight sample completes after enable drops; later ticks ignored.
        expect_sample(32'h0000_C030, CH0, "inflight_step2");
        tick();
        enable = 1'b0;
        wait_valid("inflight_step2");
        @(negedge clk);
        tick();
        repeat (4) @(negedge clk);
        check("disabled_no_valid", {31'b0, out_valid}, 32'd0);
        check("disabled_no_overrun", {31'b0, overrun}, 32'd0);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
